idex_hazard_stage: RTL and testbench
====================================

Name: idex_hazard_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core, with built-in load-use hazard detection and bubble insertion.
- Captures decoded control, operands and register indices from ID. Drives the IDEX_rs1/rs2/rd/RegWrite fields consumed by the downstream forwarding unit and EX muxes.
- Generates PC/IF-ID write enables for upstream.
- Handles data-memory stall hold, EX-resolved branch flush and a stall performance counter.

Parameters:
- XLEN, 32, datapath width of operands and immediate.
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk_i  in  1  core clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- ID_valid_i  in  1  ID holds a real instruction
- ID_rs1_i  in  5  source register 1 index
- ID_rs2_i  in  5  source register 2 index
- ID_rd_i  in  5  destination index
- ID_uses_rs1_i  in  1  instruction reads rs1
- ID_uses_rs2_i  in  1  instruction reads rs2
- ID_ctrl_i  in  8  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp[1:0]}
- ID_rs1_data_i  in  XLEN  register-file read 1
- ID_rs2_data_i  in  XLEN  register-file read 2
- ID_imm_i  in  XLEN  sign-extended immediate
- ID_funct_i  in  10  {funct7, funct3}
- flush_i  in  1  branch taken in EX; kill instruction in ID
- mem_stall_i  in  1  data memory busy; freeze whole front pipe
- IDEX_valid_o  out  1  registered valid
- IDEX_rs1_o  out  5  registered rs1
- IDEX_rs2_o  out  5  registered rs2
- IDEX_rd_o  out  5  registered rd
- IDEX_ctrl_o  out  8  registered control bundle
- IDEX_rs1_data_o  out  XLEN  registered operand 1
- IDEX_rs2_data_o  out  XLEN  registered operand 2
- IDEX_imm_o  out  XLEN  registered immediate
- IDEX_funct_o  out  10  registered funct
- PC_write_o  out  1  PC update enable (combinational)
- IFID_write_o  out  1  IF/ID register enable (combinational)
- stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_i high, async): all IDEX_* outputs are 0, stall_cnt_o is 0. While reset is held, PC_write_o=1 and IFID_write_o=1.
- load_use (combinational) = IDEX_valid_o & IDEX_ctrl_o.MemRead & (IDEX_rd_o!=0) & ID_valid_i & ((ID_uses_rs1_i & ID_rs1_i==IDEX_rd_o) | (ID_uses_rs2_i & ID_rs2_i==IDEX_rd_o)).
- Per-cycle action, strict priority, evaluated each rising edge:
  1. mem_stall_i=1 -> HOLD: all IDEX regs keep their value; PC_write_o=0, IFID_write_o=0; stall_cnt_o unchanged.
  2. flush_i=1 -> BUBBLE: IDEX_valid_o, IDEX_ctrl_o and IDEX_rd_o load 0; other fields don't-care and are loaded 0; PC_write_o=1, IFID_write_o=1. Flush overrides load_use; the redirect must be written.
  3. load_use=1 -> STALL: bubble as in 2, but PC_write_o=0 and IFID_write_o=0. stall_cnt_o increments by 1, saturating at all-ones.
  4. Otherwise -> ADVANCE: all fields load from ID_*. If ID_valid_i=0, ctrl and rd load 0. PC_write_o=1, IFID_write_o=1.
- Latency: 1 cycle from ID_* to IDEX_*.
- A load-use stall lasts exactly 1 cycle: the inserted bubble clears IDEX MemRead, so load_use deasserts the next cycle.
- rd=x0: never a hazard source; loads to x0 cause no stall.
- Both rs1 and rs2 matching: still a single-cycle stall, counted once.
- Reset asserted mid-stall: pipeline returns to the reset values above immediately. No stall persists after reset deasserts.
- Bubbles are architecturally NOPs: RegWrite=0 and MemWrite=0, so downstream forwarding sees no write.

Decomposition:
- Shared package (core_pkg):
  - ctrl bundle field positions.
  - ALUOp encodings.
  - CTRL_NOP constant = 8'h00.
  - Register index width = 5.
- Sub-module idex_hazard_detect: purely combinational load_use equation and the priority decode (PC_write, IFID_write, action select).
- Top module holds the registers and the counter.

Test Plan:
- Reset: assert rst_i for 2 cycles with random ID inputs -> all IDEX_* = 0, stall_cnt_o = 0, PC_write_o = 1.
- Load-use: lw x5 in EX, then add x6,x5,x7 in ID -> one cycle with PC_write_o = 0, IFID_write_o = 0, IDEX_ctrl_o = 0x00 next edge. The following edge IDEX_rs1_o = 5 with add's control. stall_cnt_o = 1.
- No-hazard cases: lw x0 followed by a use of x0, and lw x5 followed by an instruction with ID_uses_rs2_i = 0 and rs2 = 5 -> no stall, IDEX_* advance, stall_cnt_o unchanged.
- Priority: flush_i together with a load_use condition -> bubble, PC_write_o = 1, IFID_write_o = 1, stall_cnt_o unchanged. Then mem_stall_i together with flush_i -> IDEX_* held bit-exact for 3 cycles, PC_write_o = 0.
- Saturation: CNT_W = 2, force 5 consecutive load-use pairs -> stall_cnt_o goes 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline: control bundle layout, ALUOp codes,
// register index width and the action selected for the ID/EX register.
package core_pkg;

    localparam int REG_W   = 5;
    localparam int CTRL_W  = 8;
    localparam int FUNCT_W = 10;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    // Bit order matches ID_ctrl_i: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp}
    typedef struct packed {
        logic   reg_write;
        logic   mem_to_reg;
        logic   mem_read;
        logic   mem_write;
        logic   alu_src;
        logic   branch;
        aluop_e alu_op;
    } ctrl_t;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'b00,
        ACT_BUBBLE  = 2'b01,
        ACT_STALL   = 2'b10,
        ACT_HOLD    = 2'b11
    } idex_action_e;

endpackage

// File: rtl/idex_hazard_stage_if.sv
// ID-side inputs and ID/EX-side outputs of the hazard stage, bundled as one bus.
interface idex_hazard_stage_if #(
    parameter int XLEN = 32
);
    import core_pkg::*;

    logic                ID_valid_i;
    logic [REG_W-1:0]    ID_rs1_i;
    logic [REG_W-1:0]    ID_rs2_i;
    logic [REG_W-1:0]    ID_rd_i;
    logic                ID_uses_rs1_i;
    logic                ID_uses_rs2_i;
    logic [CTRL_W-1:0]   ID_ctrl_i;
    logic [XLEN-1:0]     ID_rs1_data_i;
    logic [XLEN-1:0]     ID_rs2_data_i;
    logic [XLEN-1:0]     ID_imm_i;
    logic [FUNCT_W-1:0]  ID_funct_i;
    logic                flush_i;
    logic                mem_stall_i;

    logic                IDEX_valid_o;
    logic [REG_W-1:0]    IDEX_rs1_o;
    logic [REG_W-1:0]    IDEX_rs2_o;
    logic [REG_W-1:0]    IDEX_rd_o;
    logic [CTRL_W-1:0]   IDEX_ctrl_o;
    logic [XLEN-1:0]     IDEX_rs1_data_o;
    logic [XLEN-1:0]     IDEX_rs2_data_o;
    logic [XLEN-1:0]     IDEX_imm_o;
    logic [FUNCT_W-1:0]  IDEX_funct_o;
    logic                PC_write_o;
    logic                IFID_write_o;

    modport slave (
        input  ID_valid_i, ID_rs1_i, ID_rs2_i, ID_rd_i, ID_uses_rs1_i, ID_uses_rs2_i,
               ID_ctrl_i, ID_rs1_data_i, ID_rs2_data_i, ID_imm_i, ID_funct_i,
               flush_i, mem_stall_i,
        output IDEX_valid_o, IDEX_rs1_o, IDEX_rs2_o, IDEX_rd_o, IDEX_ctrl_o,
               IDEX_rs1_data_o, IDEX_rs2_data_o, IDEX_imm_o, IDEX_funct_o,
               PC_write_o, IFID_write_o
    );

    modport master (
        output ID_valid_i, ID_rs1_i, ID_rs2_i, ID_rd_i, ID_uses_rs1_i, ID_uses_rs2_i,
               ID_ctrl_i, ID_rs1_data_i, ID_rs2_data_i, ID_imm_i, ID_funct_i,
               flush_i, mem_stall_i,
        input  IDEX_valid_o, IDEX_rs1_o, IDEX_rs2_o, IDEX_rd_o, IDEX_ctrl_o,
               IDEX_rs1_data_o, IDEX_rs2_data_o, IDEX_imm_o, IDEX_funct_o,
               PC_write_o, IFID_write_o
    );

endinterface

// File: rtl/idex_hazard_stage_hazard_detect.sv
// Combinational load-use detection and priority decode: hold > flush > load-use stall > advance.
module idex_hazard_detect
    import core_pkg::*;
(
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             idex_valid_i,
    input  logic             idex_mem_read_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic             flush_i,
    input  logic             mem_stall_i,
    output logic             load_use_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output idex_action_e     action_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit    = id_uses_rs1_i && (id_rs1_i == idex_rd_i);
        rs2_hit    = id_uses_rs2_i && (id_rs2_i == idex_rd_i);
        load_use_o = idex_valid_i && idex_mem_read_i && (idex_rd_i != '0) &&
                     id_valid_i && (rs1_hit || rs2_hit);

        action_o     = ACT_ADVANCE;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        if (mem_stall_i) begin
            action_o     = ACT_HOLD;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (flush_i) begin
            // The branch redirect must reach the PC, so flush wins over a pending stall.
            action_o = ACT_BUBBLE;
        end else if (load_use_o) begin
            action_o     = ACT_STALL;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end

        if (rst_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
        end
    end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, memory-stall hold,
// branch flush and a saturating stall counter.
module idex_hazard_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    idex_hazard_stage_if.slave   bus,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    logic               valid_q,     valid_d;
    logic [REG_W-1:0]   rs1_q,       rs1_d;
    logic [REG_W-1:0]   rs2_q,       rs2_d;
    logic [REG_W-1:0]   rd_q,        rd_d;
    ctrl_t              ctrl_q,      ctrl_d;
    logic [XLEN-1:0]    rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]    imm_q,       imm_d;
    logic [FUNCT_W-1:0] funct_q,     funct_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               load_use;
    idex_action_e       action;

    idex_hazard_detect u_detect (
        .rst_i           (rst_i),
        .id_valid_i      (bus.ID_valid_i),
        .id_rs1_i        (bus.ID_rs1_i),
        .id_rs2_i        (bus.ID_rs2_i),
        .id_uses_rs1_i   (bus.ID_uses_rs1_i),
        .id_uses_rs2_i   (bus.ID_uses_rs2_i),
        .idex_valid_i    (valid_q),
        .idex_mem_read_i (ctrl_q.mem_read),
        .idex_rd_i       (rd_q),
        .flush_i         (bus.flush_i),
        .mem_stall_i     (bus.mem_stall_i),
        .load_use_o      (load_use),
        .pc_write_o      (bus.PC_write_o),
        .ifid_write_o    (bus.IFID_write_o),
        .action_o        (action)
    );

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        funct_d     = funct_q;
        stall_cnt_d = stall_cnt_q;

        case (action)
            ACT_HOLD: ;
            ACT_BUBBLE, ACT_STALL: begin
                // A bubble clears MemRead, so a load-use stall never outlasts one cycle.
                valid_d    = 1'b0;
                rs1_d      = '0;
                rs2_d      = '0;
                rd_d       = '0;
                ctrl_d     = ctrl_t'(CTRL_NOP);
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
                funct_d    = '0;
                if (action == ACT_STALL && !(&stall_cnt_q)) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: begin
                valid_d    = bus.ID_valid_i;
                rs1_d      = bus.ID_rs1_i;
                rs2_d      = bus.ID_rs2_i;
                rd_d       = bus.ID_valid_i ? bus.ID_rd_i : '0;
                ctrl_d     = bus.ID_valid_i ? ctrl_t'(bus.ID_ctrl_i) : ctrl_t'(CTRL_NOP);
                rs1_data_d = bus.ID_rs1_data_i;
                rs2_data_d = bus.ID_rs2_data_i;
                imm_d      = bus.ID_imm_i;
                funct_d    = bus.ID_funct_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= ctrl_t'(CTRL_NOP);
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            funct_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            funct_q     <= funct_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.IDEX_valid_o    = valid_q;
    assign bus.IDEX_rs1_o      = rs1_q;
    assign bus.IDEX_rs2_o      = rs2_q;
    assign bus.IDEX_rd_o       = rd_q;
    assign bus.IDEX_ctrl_o     = ctrl_q;
    assign bus.IDEX_rs1_data_o = rs1_data_q;
    assign bus.IDEX_rs2_data_o = rs2_data_q;
    assign bus.IDEX_imm_o      = imm_q;
    assign bus.IDEX_funct_o    = funct_q;
    assign stall_cnt_o         = stall_cnt_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed bench for idex_hazard_stage: a vector table plus hand-written reset,
// saturation and reset-during-stall sequences. Counter width is 2 to reach saturation.
module tb_idex_hazard_stage;

    localparam logic [7:0] C_LW   = 8'hE8;
    localparam logic [7:0] C_ADD  = 8'h82;
    localparam logic [7:0] C_ADDI = 8'h8B;
    localparam int NV = 21;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] stall_cnt;
    int         n_cmp  = 0;
    int         n_fail = 0;

    idex_hazard_stage_if #(.XLEN(32)) bus ();

    idex_hazard_stage #(.XLEN(32), .CNT_W(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2;
        logic [7:0] ctrl;
        logic       fl, ms;
        logic       e_pcw, e_ifid, e_v;
        logic [4:0] e_rd;
        logic [7:0] e_ctrl;
        int         e_didx;
        int         e_cnt;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u1, input logic u2,
                                input logic [7:0] ctrl, input logic fl, input logic ms,
                                input logic e_pcw, input logic e_ifid, input logic e_v,
                                input logic [4:0] e_rd, input logic [7:0] e_ctrl,
                                input int e_didx, input int e_cnt);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2;
        r.ctrl = ctrl; r.fl = fl; r.ms = ms;
        r.e_pcw = e_pcw; r.e_ifid = e_ifid; r.e_v = e_v; r.e_rd = e_rd;
        r.e_ctrl = e_ctrl; r.e_didx = e_didx; r.e_cnt = e_cnt;
        return r;
    endfunction

    function automatic logic [31:0] rs1_dat(input int i); return 32'hA000_0000 + i; endfunction
    function automatic logic [31:0] rs2_dat(input int i); return 32'hB000_0000 + i; endfunction
    function automatic logic [31:0] imm_dat(input int i); return 32'hC000_0000 + i; endfunction
    function automatic logic [9:0]  fn_dat (input int i); return 10'h100 + 10'(i); endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [7:0] ctrl, input logic fl, input logic ms, input int idx);
        bus.ID_valid_i    = v;
        bus.ID_rs1_i      = rs1;
        bus.ID_rs2_i      = rs2;
        bus.ID_rd_i       = rd;
        bus.ID_uses_rs1_i = u1;
        bus.ID_uses_rs2_i = u2;
        bus.ID_ctrl_i     = ctrl;
        bus.ID_rs1_data_i = rs1_dat(idx);
        bus.ID_rs2_data_i = rs2_dat(idx);
        bus.ID_imm_i      = imm_dat(idx);
        bus.ID_funct_i    = fn_dat(idx);
        bus.flush_i       = fl;
        bus.mem_stall_i   = ms;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(bus.IDEX_valid_o), 32'h0);
        check({tag, ".rd"},    32'(bus.IDEX_rd_o),    32'h0);
        check({tag, ".rs1"},   32'(bus.IDEX_rs1_o),   32'h0);
        check({tag, ".rs2"},   32'(bus.IDEX_rs2_o),   32'h0);
        check({tag, ".ctrl"},  32'(bus.IDEX_ctrl_o),  32'h0);
        check({tag, ".d1"},    bus.IDEX_rs1_data_o,   32'h0);
        check({tag, ".d2"},    bus.IDEX_rs2_data_o,   32'h0);
        check({tag, ".imm"},   bus.IDEX_imm_o,        32'h0);
        check({tag, ".funct"}, 32'(bus.IDEX_funct_o), 32'h0);
        check({tag, ".cnt"},   32'(stall_cnt),        32'h0);
        check({tag, ".pcw"},   32'(bus.PC_write_o),   32'h1);
        check({tag, ".ifidw"}, 32'(bus.IFID_write_o), 32'h1);
    endtask

    initial begin
        //             v  rs1 rs2 rd u1 u2 ctrl   fl ms | pcw ifid v  rd  ctrl   didx cnt
        tbl[0]  = mk(1, 1, 0, 5,  1, 0, C_LW,   0, 0,   1, 1, 1, 5, C_LW,   0, 0);
        tbl[1]  = mk(1, 5, 7, 6,  1, 1, C_ADD,  0, 0,   0, 0, 0, 0, 8'h00, -1, 1);
        tbl[2]  = mk(1, 5, 7, 6,  1, 1, C_ADD,  0, 0,   1, 1, 1, 6, C_ADD,  2, 1);
        tbl[3]  = mk(1, 2, 0, 0,  1, 0, C_LW,   0, 0,   1, 1, 1, 0, C_LW,   3, 1);
        tbl[4]  = mk(1, 0, 0, 8,  1, 1, C_ADD,  0, 0,   1, 1, 1, 8, C_ADD,  4, 1);
        tbl[5]  = mk(1, 3, 0, 5,  1, 0, C_LW,   0, 0,   1, 1, 1, 5, C_LW,   5, 1);
        tbl[6]  = mk(1, 1, 5, 9,  1, 0, C_ADDI, 0, 0,   1, 1, 1, 9, C_ADDI, 6, 1);
        tbl[7]  = mk(1, 4, 0, 5,  1, 0, C_LW,   0, 0,   1, 1, 1, 5, C_LW,   7, 1);
        tbl[8]  = mk(1, 5, 5, 6,  1, 1, C_ADD,  1, 0,   1, 1, 0, 0, 8'h00, -1, 1);
        tbl[9]  = mk(1, 6, 0, 5,  1, 0, C_LW,   0, 0,   1, 1, 1, 5, C_LW,   9, 1);
        tbl[10] = mk(1, 5, 7, 6,  1, 1, C_ADD,  1, 1,   0, 0, 1, 5, C_LW,   9, 1);
        tbl[11] = mk(1, 5, 7, 6,  1, 1, C_ADD,  1, 1,   0, 0, 1, 5, C_LW,   9, 1);
        tbl[12] = mk(1, 5, 7, 6,  1, 1, C_ADD,  1, 1,   0, 0, 1, 5, C_LW,   9, 1);
        tbl[13] = mk(1, 5, 7, 6,  1, 1, C_ADD,  0, 0,   0, 0, 0, 0, 8'h00, -1, 2);
        tbl[14] = mk(1, 5, 7, 6,  1, 1, C_ADD,  0, 0,   1, 1, 1, 6, C_ADD, 14, 2);
        tbl[15] = mk(1, 7, 0, 5,  1, 0, C_LW,   0, 0,   1, 1, 1, 5, C_LW,  15, 2);
        tbl[16] = mk(1, 5, 5, 6,  1, 1, C_ADD,  0, 0,   0, 0, 0, 0, 8'h00, -1, 3);
        tbl[17] = mk(1, 5, 5, 6,  1, 1, C_ADD,  0, 0,   1, 1, 1, 6, C_ADD, 17, 3);
        tbl[18] = mk(0, 9, 10, 11, 1, 1, C_ADD, 0, 0,   1, 1, 0, 0, 8'h00, 18, 3);
        tbl[19] = mk(1, 8, 0, 5,  1, 0, C_LW,   0, 0,   1, 1, 1, 5, C_LW,  19, 3);
        tbl[20] = mk(0, 5, 5, 6,  1, 1, C_ADD,  0, 0,   1, 1, 0, 0, 8'h00, 20, 3);

        // Reset held for two edges with random ID inputs.
        rst = 1'b1;
        drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
              1'($urandom), 8'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 255)));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check_zero($sformatf("reset%0d", c));
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2,
                  tbl[i].ctrl, tbl[i].fl, tbl[i].ms, i);
            #1;
            check($sformatf("v%0d.pcw", i),   32'(bus.PC_write_o),   32'(tbl[i].e_pcw));
            check($sformatf("v%0d.ifidw", i), 32'(bus.IFID_write_o), 32'(tbl[i].e_ifid));
            @(posedge clk);
            #1;
            check($sformatf("v%0d.valid", i), 32'(bus.IDEX_valid_o), 32'(tbl[i].e_v));
            check($sformatf("v%0d.rd", i),    32'(bus.IDEX_rd_o),    32'(tbl[i].e_rd));
            check($sformatf("v%0d.ctrl", i),  32'(bus.IDEX_ctrl_o),  32'(tbl[i].e_ctrl));
            check($sformatf("v%0d.cnt", i),   32'(stall_cnt),        32'(tbl[i].e_cnt));
            if (tbl[i].e_didx < 0) begin
                check($sformatf("v%0d.rs1", i),   32'(bus.IDEX_rs1_o),   32'h0);
                check($sformatf("v%0d.rs2", i),   32'(bus.IDEX_rs2_o),   32'h0);
                check($sformatf("v%0d.d1", i),    bus.IDEX_rs1_data_o,   32'h0);
                check($sformatf("v%0d.d2", i),    bus.IDEX_rs2_data_o,   32'h0);
                check($sformatf("v%0d.imm", i),   bus.IDEX_imm_o,        32'h0);
                check($sformatf("v%0d.funct", i), 32'(bus.IDEX_funct_o), 32'h0);
            end else begin
                check($sformatf("v%0d.rs1", i),   32'(bus.IDEX_rs1_o),   32'(tbl[tbl[i].e_didx].rs1));
                check($sformatf("v%0d.rs2", i),   32'(bus.IDEX_rs2_o),   32'(tbl[tbl[i].e_didx].rs2));
                check($sformatf("v%0d.d1", i),    bus.IDEX_rs1_data_o,   rs1_dat(tbl[i].e_didx));
                check($sformatf("v%0d.d2", i),    bus.IDEX_rs2_data_o,   rs2_dat(tbl[i].e_didx));
                check($sformatf("v%0d.imm", i),   bus.IDEX_imm_o,        imm_dat(tbl[i].e_didx));
                check($sformatf("v%0d.funct", i), 32'(bus.IDEX_funct_o), 32'(fn_dat(tbl[i].e_didx)));
            end
        end

        // Saturation: five back-to-back lw x5 / add x6,x5,x7 pairs from a clean counter.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("sat.rst_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(1, 1, 0, 5, 1, 0, C_LW, 0, 0, 100 + k);
            @(posedge clk);
            @(negedge clk);
            drive(1, 5, 7, 6, 1, 1, C_ADD, 0, 0, 200 + k);
            #1;
            check($sformatf("sat%0d.pcw", k), 32'(bus.PC_write_o), 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d.cnt", k),  32'(stall_cnt),       32'((k < 3) ? k : 3));
            check($sformatf("sat%0d.ctrl", k), 32'(bus.IDEX_ctrl_o), 32'h0);
        end

        // Reset arriving while a load-use stall is pending.
        @(negedge clk);
        drive(1, 1, 0, 5, 1, 0, C_LW, 0, 0, 300);
        @(posedge clk);
        @(negedge clk);
        drive(1, 5, 7, 6, 1, 1, C_ADD, 0, 0, 301);
        #1;
        check("rstmid.pcw_before", 32'(bus.PC_write_o), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rstmid");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid.pcw_after", 32'(bus.PC_write_o), 32'h1);
        @(posedge clk);
        #1;
        check("rstmid.valid", 32'(bus.IDEX_valid_o), 32'h1);
        check("rstmid.rd",    32'(bus.IDEX_rd_o),    32'h6);
        check("rstmid.ctrl",  32'(bus.IDEX_ctrl_o),  32'(C_ADD));
        check("rstmid.cnt",   32'(stall_cnt),        32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
